// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// parking_gate_arbiter
// ----------------------------------------------------------------------------
// Controls the single shared barrier gate of the parking lot. Entry and exit
// requests are arbitrated round-robin. Cars entering must present a two-digit
// password. Occupancy is tracked against a fixed capacity. Repeated wrong
// passwords put the gate into a timed lockout.
//
// Ports:
//   clk          system clock, rising edge active
//   reset        asynchronous, active-low reset
//   sensor_ent   car present at the entry lane
//   sensor_exit  car present at the exit lane
//   pass_1       first password digit
//   pass_2       second password digit
//   pass_valid   one-cycle strobe, pass_1/pass_2 are valid
//   gate_open    barrier raised
//   gate_dir     1 = entry grant, 0 = exit grant (meaningful while gate_open)
//   green_led    proceed
//   red_led      stop / wrong password / lot full / lockout
//   occupancy    cars currently inside
//   full         occupancy == CAPACITY
//   empty        occupancy == 0
//   lockout      gate is in the lockout state
//
// Every output is registered. It is computed from the next state, so outputs
// and state change together on one clock edge.
// ============================================================================
module parking_gate_arbiter #(
    parameter int         CAPACITY     = 8,
    parameter int         CNT_W        = 4,
    parameter int         OPEN_CYCLES  = 16,
    parameter int         PASS_TIMEOUT = 64,
    parameter int         MAX_TRIES    = 3,
    parameter int         LOCK_CYCLES  = 128,
    parameter logic [1:0] PASS_1_VAL   = 2'b01,
    parameter logic [1:0] PASS_2_VAL   = 2'b10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_ent,
    input  logic             sensor_exit,
    input  logic [1:0]       pass_1,
    input  logic [1:0]       pass_2,
    input  logic             pass_valid,
    output logic             gate_open,
    output logic             gate_dir,
    output logic             green_led,
    output logic             red_led,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             lockout
);

    // A wrong password on the last WAIT_PASS cycle keeps the timer counting
    // past PASS_TIMEOUT for a few extra cycles. The width is sized on the sum
    // of all windows so the timer can never wrap.
    localparam int TIMER_W = $clog2(OPEN_CYCLES + PASS_TIMEOUT + LOCK_CYCLES + MAX_TRIES + 1);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    localparam logic [TIMER_W-1:0] OPEN_LAST    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(PASS_TIMEOUT - 1);
    localparam logic [TRIES_W-1:0] TRIES_LIMIT  = TRIES_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0]   CAP_VAL      = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PASS,
        OPEN_ENT,
        OPEN_EXIT,
        LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TRIES_W-1:0] tries_q, tries_d;

    // last_grant: 0 = entry, 1 = exit. It resets to 0, so the first contested
    // grant after reset goes to the exit lane.
    logic               last_grant_q, last_grant_d;

    logic [CNT_W-1:0]   occupancy_d;
    logic               gate_open_d;
    logic               gate_dir_d;
    logic               green_led_d;
    logic               red_led_d;
    logic               full_d;
    logic               empty_d;
    logic               lockout_d;

    logic               exit_req;
    logic               ent_req;
    logic               pass_ok;
    logic [TRIES_W-1:0] tries_inc;

    // Eligibility uses the registered full/empty flags, which always match
    // the registered occupancy. A full lot therefore never grants entry, and
    // an empty lot never grants exit. This keeps the occupancy count from
    // wrapping.
    assign exit_req  = sensor_exit & ~empty;
    assign ent_req   = sensor_ent & ~full;
    assign pass_ok   = (pass_1 == PASS_1_VAL) && (pass_2 == PASS_2_VAL);
    assign tries_inc = tries_q + TRIES_W'(1);

    // Next-state logic: arbitration, password checking and the timed windows.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        tries_d      = tries_q;
        last_grant_d = last_grant_q;
        occupancy_d  = occupancy;

        case (state_q)
            IDLE: begin
                // Exit wins when it is the only request. It also wins on a
                // tie when entry was served last.
                if (exit_req && (!ent_req || !last_grant_q)) begin
                    state_d      = OPEN_EXIT;
                    timer_d      = '0;
                    last_grant_d = 1'b1;
                end else if (ent_req) begin
                    state_d = WAIT_PASS;
                    timer_d = '0;
                    tries_d = '0;
                end
            end

            WAIT_PASS: begin
                // A strobe outranks a dropped sensor, and a dropped sensor
                // outranks the timeout.
                if (pass_valid) begin
                    if (pass_ok) begin
                        state_d      = OPEN_ENT;
                        timer_d      = '0;
                        last_grant_d = 1'b0;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TRIES_LIMIT) begin
                            state_d = LOCK;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + TIMER_W'(1);
                        end
                    end
                end else if (!sensor_ent) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tries_d = '0;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            OPEN_ENT: begin
                // The gate stays up for the whole window, whatever the
                // sensors do. The car is counted as the gate closes.
                if (timer_q == OPEN_LAST) begin
                    state_d     = IDLE;
                    timer_d     = '0;
                    occupancy_d = occupancy + CNT_W'(1);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            OPEN_EXIT: begin
                if (timer_q == OPEN_LAST) begin
                    state_d     = IDLE;
                    timer_d     = '0;
                    occupancy_d = occupancy - CNT_W'(1);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            LOCK: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
                tries_d = '0;
            end
        endcase
    end

    // Output decode from the next state, so that registered outputs line up
    // with the state register. In IDLE the red LED warns a waiting entry car
    // that the lot is full. It uses the post-edge occupancy, so it lights at
    // once when the last free space is taken.
    always_comb begin
        full_d      = (occupancy_d == CAP_VAL);
        empty_d     = (occupancy_d == '0);
        gate_open_d = (state_d == OPEN_ENT) || (state_d == OPEN_EXIT);
        gate_dir_d  = (state_d == OPEN_ENT);
        green_led_d = gate_open_d;
        lockout_d   = (state_d == LOCK);
        red_led_d   = 1'b0;
        case (state_d)
            WAIT_PASS: red_led_d = 1'b1;
            LOCK:      red_led_d = 1'b1;
            IDLE:      red_led_d = sensor_ent & full_d;
            default:   red_led_d = 1'b0;
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            tries_q      <= '0;
            last_grant_q <= 1'b0;
            occupancy    <= '0;
            gate_open    <= 1'b0;
            gate_dir     <= 1'b0;
            green_led    <= 1'b0;
            red_led      <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            lockout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            tries_q      <= tries_d;
            last_grant_q <= last_grant_d;
            occupancy    <= occupancy_d;
            gate_open    <= gate_open_d;
            gate_dir     <= gate_dir_d;
            green_led    <= green_led_d;
            red_led      <= red_led_d;
            full         <= full_d;
            empty        <= empty_d;
            lockout      <= lockout_d;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
// tb_parking_gate_arbiter
// ----------------------------------------------------------------------------
// Scoreboard bench for parking_gate_arbiter.
//
// Every negedge, the stimulus process drives the inputs. It then advances the
// lot model, which tracks the phase, the cycles left in that phase and the
// cars counted inside. The output vector expected after the next rising edge
// is pushed onto a queue. On every rising edge, a monitor pops one entry and
// compares it with the DUT outputs.
// ============================================================================
module tb_parking_gate_arbiter;

    localparam int CAPACITY     = 8;
    localparam int CNT_W        = 4;
    localparam int OPEN_CYCLES  = 16;
    localparam int PASS_TIMEOUT = 64;
    localparam int MAX_TRIES    = 3;
    localparam int LOCK_CYCLES  = 128;
    localparam int VW           = 7 + CNT_W;

    logic             clk;
    logic             reset;
    logic             sensor_ent;
    logic             sensor_exit;
    logic [1:0]       pass_1;
    logic [1:0]       pass_2;
    logic             pass_valid;
    logic             gate_open;
    logic             gate_dir;
    logic             green_led;
    logic             red_led;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             lockout;

    parking_gate_arbiter #(
        .CAPACITY    (CAPACITY),
        .CNT_W       (CNT_W),
        .OPEN_CYCLES (OPEN_CYCLES),
        .PASS_TIMEOUT(PASS_TIMEOUT),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .PASS_1_VAL  (2'b01),
        .PASS_2_VAL  (2'b10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_ent (sensor_ent),
        .sensor_exit(sensor_exit),
        .pass_1     (pass_1),
        .pass_2     (pass_2),
        .pass_valid (pass_valid),
        .gate_open  (gate_open),
        .gate_dir   (gate_dir),
        .green_led  (green_led),
        .red_led    (red_led),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty),
        .lockout    (lockout)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] exp_q[$];

    // Lot model: the current phase, the cycles left in it, the wrong
    // attempts so far, the lane served last and the car count.
    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_IN   = 2;
    localparam int PH_OUT  = 3;
    localparam int PH_LOCK = 4;

    int m_phase;
    int m_left;
    int m_tries;
    int m_occ;
    bit m_last_exit;

    function automatic void model_reset();
        m_phase     = PH_IDLE;
        m_left      = 0;
        m_tries     = 0;
        m_occ       = 0;
        m_last_exit = 1'b0;
    endfunction

    function automatic void model_step(bit se, bit sx, logic [1:0] p1, logic [1:0] p2, bit pv);
        bit want_out;
        bit want_in;
        want_out = sx && (m_occ > 0);
        want_in  = se && (m_occ < CAPACITY);
        case (m_phase)
            PH_IDLE: begin
                if (want_out && (!want_in || !m_last_exit)) begin
                    m_phase     = PH_OUT;
                    m_left      = OPEN_CYCLES;
                    m_last_exit = 1'b1;
                end else if (want_in) begin
                    m_phase = PH_WAIT;
                    m_left  = PASS_TIMEOUT;
                    m_tries = 0;
                end
            end
            PH_WAIT: begin
                if (pv) begin
                    if (p1 == 2'd1 && p2 == 2'd2) begin
                        m_phase     = PH_IN;
                        m_left      = OPEN_CYCLES;
                        m_last_exit = 1'b0;
                    end else begin
                        m_tries = m_tries + 1;
                        if (m_tries == MAX_TRIES) begin
                            m_phase = PH_LOCK;
                            m_left  = LOCK_CYCLES;
                        end else begin
                            m_left = m_left - 1;
                        end
                    end
                end else if (!se || m_left <= 1) begin
                    m_phase = PH_IDLE;
                    m_tries = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end
            PH_IN, PH_OUT: begin
                if (m_left == 1) begin
                    m_occ   = (m_phase == PH_IN) ? m_occ + 1 : m_occ - 1;
                    m_phase = PH_IDLE;
                end else begin
                    m_left = m_left - 1;
                end
            end
            default: begin
                if (m_left == 1) begin
                    m_phase = PH_IDLE;
                    m_tries = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end
        endcase
    endfunction

    function automatic logic [VW-1:0] model_vec(bit se);
        bit up;
        bit red;
        up  = (m_phase == PH_IN) || (m_phase == PH_OUT);
        red = (m_phase == PH_WAIT) || (m_phase == PH_LOCK) ||
              ((m_phase == PH_IDLE) && se && (m_occ == CAPACITY));
        return {up, (m_phase == PH_IN), up, red, CNT_W'(m_occ),
                (m_occ == CAPACITY), (m_occ == 0), (m_phase == PH_LOCK)};
    endfunction

    function automatic string fmt(logic [VW-1:0] v);
        return $sformatf("open=%0b dir=%0b grn=%0b red=%0b occ=%0d full=%0b empty=%0b lock=%0b",
                         v[VW-1], v[VW-2], v[VW-3], v[VW-4], v[VW-5 -: CNT_W], v[2], v[1], v[0]);
    endfunction

    task automatic check_output(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %s, expected %s", name, $time, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_value(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // The monitor compares one queued expectation after each rising edge.
    always @(posedge clk) begin
        logic [VW-1:0] exp_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_output("outputs", {gate_open, gate_dir, green_led, red_led, occupancy,
                                     full, empty, lockout}, exp_v);
        end
    end

    // Each call is entered at a negedge. It drives one cycle of inputs,
    // records the expected outcome of the next edge and returns at the
    // following negedge.
    task automatic apply_stimulus(input bit se, input bit sx, input logic [1:0] p1,
                                  input logic [1:0] p2, input bit pv);
        sensor_ent  = se;
        sensor_exit = sx;
        pass_1      = p1;
        pass_2      = p2;
        pass_valid  = pv;
        model_step(se, sx, p1, p2, pv);
        exp_q.push_back(model_vec(se));
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_value("reset_gate_open", int'(gate_open), 0);
        check_value("reset_occupancy", int'(occupancy), 0);
        repeat (n) begin
            exp_q.push_back(model_vec(sensor_ent));
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic enter_car();
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd1, 2'd2, 1'b1);
        idle_cycles(OPEN_CYCLES);
    endtask

    task automatic exit_car();
        apply_stimulus(1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
        idle_cycles(OPEN_CYCLES);
    endtask

    initial begin
        reset       = 1'b0;
        sensor_ent  = 1'b0;
        sensor_exit = 1'b0;
        pass_1      = 2'd0;
        pass_2      = 2'd0;
        pass_valid  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(10);

        // Single entry with the correct password.
        enter_car();
        idle_cycles(2);

        // Three wrong passwords lead to lockout, then a correct entry.
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        repeat (3) apply_stimulus(1'b1, 1'b0, 2'd3, 2'd0, 1'b1);
        idle_cycles(LOCK_CYCLES + 2);
        enter_car();

        // Fill the lot, then hold a car at the full entry and release one car.
        while (m_occ < CAPACITY) enter_car();
        repeat (5) apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
        idle_cycles(OPEN_CYCLES + 1);

        // Drain to three cars, let one in, then contend on both lanes.
        while (m_occ > 3) exit_car();
        enter_car();
        repeat (70) apply_stimulus(1'b1, 1'b1, 2'd1, 2'd2, 1'b1);
        idle_cycles(2);

        // Password timeout, a dropped entry sensor, exit requested while empty.
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        repeat (PASS_TIMEOUT + 1) apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        idle_cycles(1);
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        idle_cycles(2);
        while (m_occ > 0) exit_car();
        repeat (4) apply_stimulus(1'b0, 1'b1, 2'd0, 2'd0, 1'b0);

        // Reset in the middle of an entry window.
        enter_car();
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd1, 2'd2, 1'b1);
        idle_cycles(5);
        do_reset(3);
        enter_car();
        exit_car();

        // Random traffic, with the exit rate varied per block so the lot
        // swings between empty and full.
        for (int blk = 0; blk < 8; blk++) begin
            int exit_pct;
            exit_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 40 : 20);
            for (int i = 0; i < 500; i++) begin
                bit se;
                bit sx;
                bit pv;
                logic [1:0] p1;
                logic [1:0] p2;
                se = ($urandom_range(99) < 70);
                sx = ($urandom_range(99) < exit_pct);
                pv = ($urandom_range(99) < 15);
                if ($urandom_range(99) < 60) begin
                    p1 = 2'd1;
                    p2 = 2'd2;
                end else begin
                    p1 = 2'($urandom);
                    p2 = 2'($urandom);
                end
                apply_stimulus(se, sx, p1, p2, pv);
            end
        end
        idle_cycles(2);

        @(posedge clk);
        #2;
        check_value("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
